masked_streaming_histogram: RTL and testbench

- Next-generation streaming histogram with per-lane keep mask, runtime clear, busy/ready status, dropped-beat accounting and a valid-qualified query port.
- Counts occurrences of each word value across 2**log2_words lanes per beat into 2**word_width bins.
- Sits after the stream source; software/monitor logic reads bins through the query port.

---
 rtl/masked_streaming_histogram.sv | 215 +++++++++++++++++++++
 tb/tb_masked_streaming_histogram.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_streaming_histogram.sv
// masked_streaming_histogram: counts word values across all kept lanes of each
// stream beat into 2**word_width bins, with a sweep-based clear, a dropped-beat
// counter and a three-cycle pipelined query port.
// Build macro HIST_SATURATE_EN: when defined, bins stick at all-ones instead of
// wrapping around.
module masked_streaming_histogram #(
   parameter int log2_words  = 3,
   parameter int word_width  = 12,
   parameter int count_width = 48,
   parameter int drop_width  = 16
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  clear,
   output logic                                  busy,
   input  logic                                  stream_valid,
   input  logic [(2**log2_words)-1:0]            stream_keep,
   input  logic [word_width*(2**log2_words)-1:0] stream_data,
   input  logic                                  query_valid,
   input  logic [word_width-1:0]                 query_word,
   output logic                                  query_count_valid,
   output logic [count_width-1:0]               query_count,
   output logic [drop_width-1:0]                drop_count
);

   localparam int lanes      = 2**log2_words;
   localparam int numBins    = 2**word_width;
   localparam int data_width = word_width*lanes;
   localparam int incWidth   = log2_words+1;

   typedef enum logic {SWEEP, RUN} state_t;

   state_t                  state_q, state_d;
   logic [word_width-1:0]   sweepIdx_q, sweepIdx_d;
   logic [drop_width-1:0]   dropCount_q, dropCount_d;
   logic                    accept;

   logic                    beatValid_q;
   logic [data_width-1:0]   beatData_q;
   logic [lanes-1:0]        beatKeep_q;

   logic [lanes-1:0][word_width-1:0] laneWord;
   logic [lanes-1:0][incWidth-1:0]   laneInc;
   logic [lanes-1:0]                 laneLead;

   logic                             mergeValid_q;
   logic [lanes-1:0]                 mergeLead_q;
   logic [lanes-1:0][word_width-1:0] mergeWord_q;
   logic [lanes-1:0][incWidth-1:0]   mergeInc_q;

   logic [count_width-1:0]  bins_q   [numBins];
   logic [count_width-1:0]  binsNext [numBins];

   logic                    q1Valid_q, q1Busy_q;
   logic [word_width-1:0]   q1Word_q;
   logic                    q2Valid_q;
   logic [count_width-1:0]  q2Count_q;
   logic                    q3Valid_q;
   logic [count_width-1:0]  q3Count_q;

   // Adds a per-beat increment to a bin, either wrapping or sticking at all-ones.
   function automatic logic [count_width-1:0] addInc(input logic [count_width-1:0] base,
                                                      input logic [incWidth-1:0] inc);
`ifdef HIST_SATURATE_EN
      logic [count_width:0] sum;
      sum = {1'b0, base} + (count_width+1)'(inc);
      addInc = sum[count_width] ? '1 : sum[count_width-1:0];
`else
      addInc = base + count_width'(inc);
`endif
   endfunction

   assign busy   = (state_q == SWEEP);
   assign accept = stream_valid && (state_q == RUN);

   // Sweep/run sequencing, sweep index and the saturating dropped-beat counter.
   always_comb begin
      state_d     = state_q;
      sweepIdx_d  = sweepIdx_q;
      dropCount_d = dropCount_q;
      case (state_q)
         SWEEP: begin
            if (clear) begin
               sweepIdx_d = '0;
            end else if (sweepIdx_q == '1) begin
               sweepIdx_d = '0;
               state_d    = RUN;
            end else begin
               sweepIdx_d = sweepIdx_q + word_width'(1);
            end
            if (stream_valid && (dropCount_q != '1)) begin
               dropCount_d = dropCount_q + drop_width'(1);
            end
         end
         RUN: begin
            if (clear) begin
               state_d     = SWEEP;
               sweepIdx_d  = '0;
               dropCount_d = '0;
            end
         end
         default: begin
            state_d    = SWEEP;
            sweepIdx_d = '0;
         end
      endcase
   end

   // Control state register; reset always restarts a full sweep.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SWEEP;
         sweepIdx_q  <= '0;
         dropCount_q <= '0;
      end else begin
         state_q     <= state_d;
         sweepIdx_q  <= sweepIdx_d;
         dropCount_q <= dropCount_d;
      end
   end

   // Merge duplicate words in a beat: the first kept lane holding a word carries
   // the whole count for that word, so each bin is written at most once per beat.
   always_comb begin
      laneWord = '0;
      laneInc  = '0;
      laneLead = '0;
      for (int k = 0; k < lanes; k++) begin
         laneWord[k] = beatData_q[k*word_width +: word_width];
      end
      for (int k = 0; k < lanes; k++) begin
         laneLead[k] = beatKeep_q[k];
         for (int j = 0; j < lanes; j++) begin
            if (beatKeep_q[j] && (laneWord[j] == laneWord[k])) begin
               laneInc[k] = laneInc[k] + incWidth'(1);
               if (j < k) begin
                  laneLead[k] = 1'b0;
               end
            end
         end
      end
   end

   // Beat pipeline: capture, then merge; a clear flushes beats still in flight so
   // nothing lands in a bin the sweep has already zeroed.
   always_ff @(posedge clk) begin
      if (rst) begin
         beatValid_q  <= 1'b0;
         beatData_q   <= '0;
         beatKeep_q   <= '0;
         mergeValid_q <= 1'b0;
         mergeLead_q  <= '0;
         mergeWord_q  <= '0;
         mergeInc_q   <= '0;
      end else begin
         beatValid_q  <= accept && !clear;
         beatData_q   <= stream_data;
         beatKeep_q   <= stream_keep;
         mergeValid_q <= beatValid_q && !clear;
         mergeLead_q  <= laneLead;
         mergeWord_q  <= laneWord;
         mergeInc_q   <= laneInc;
      end
   end

   // Next bin contents: read-modify-write happens in one cycle against the
   // current array, so back-to-back beats on the same bin see each other.
   always_comb begin
      binsNext = bins_q;
      if (mergeValid_q) begin
         for (int k = 0; k < lanes; k++) begin
            if (mergeLead_q[k]) begin
               binsNext[mergeWord_q[k]] = addInc(bins_q[mergeWord_q[k]], mergeInc_q[k]);
            end
         end
      end
      if (state_q == SWEEP) begin
         binsNext[sweepIdx_q] = '0;
      end
   end

   // Bin storage; the sweep provides the clearing, so no reset is needed here.
   always_ff @(posedge clk) begin
      bins_q <= binsNext;
   end

   // Query pipeline: register request, read bin (forced to zero if requested while
   // busy), then present; the count holds when no query is returning.
   always_ff @(posedge clk) begin
      if (rst) begin
         q1Valid_q <= 1'b0;
         q1Busy_q  <= 1'b0;
         q1Word_q  <= '0;
         q2Valid_q <= 1'b0;
         q2Count_q <= '0;
         q3Valid_q <= 1'b0;
         q3Count_q <= '0;
      end else begin
         q1Valid_q <= query_valid;
         q1Busy_q  <= busy;
         q1Word_q  <= query_word;
         q2Valid_q <= q1Valid_q;
         q2Count_q <= q1Busy_q ? '0 : bins_q[q1Word_q];
         q3Valid_q <= q2Valid_q;
         if (q2Valid_q) begin
            q3Count_q <= q2Count_q;
         end
      end
   end

   assign query_count_valid = q3Valid_q;
   assign query_count       = q3Count_q;
   assign drop_count        = dropCount_q;

endmodule

// File: tb/tb_masked_streaming_histogram.sv
// Testbench for masked_streaming_histogram: directed query tables, multi-cycle
// sweep/clear/saturation sequences and a randomised stream against a bin model.
module tb_masked_streaming_histogram;

   localparam int L  = 8;
   localparam int WW = 12;
   localparam int CW = 48;
   localparam int N  = 4096;
   localparam int DW = WW*L;

   typedef struct {
      logic [WW-1:0] word;
      logic [CW-1:0] expCount;
   } qvec_t;

   typedef struct {
      bit            valid;
      bit            busy;
      logic [WW-1:0] word;
      logic [CW-1:0] base;
      logic [CW-1:0] inc3;
      logic [CW-1:0] inc2;
      logic [CW-1:0] inc1;
      logic [CW-1:0] inc0;
   } qrec_t;

   logic          clk = 1'b0;
   logic          rst, clear, stream_valid, query_valid;
   logic [L-1:0]  stream_keep;
   logic [DW-1:0] stream_data;
   logic [WW-1:0] query_word;
   logic          busy, query_count_valid;
   logic [CW-1:0] query_count;
   logic [15:0]   drop_count;

   logic          clear4, sv4, qv4;
   logic [L-1:0]  keep4;
   logic [DW-1:0] data4;
   logic [WW-1:0] qw4;
   logic          busy4, qcv4;
   logic [3:0]    qc4, drop4;

   int errors = 0;
   int checks = 0;

   qvec_t runTable[$];
   qvec_t zeroTable[$];
   qrec_t recQ[$];

   logic [CW-1:0] modelBins [N];
   int            modelRem  = 0;
   int            modelDrop = 0;
   bit            ringAcc  [4];
   logic [DW-1:0] ringData [4];
   logic [L-1:0]  ringKeep [4];

   always #5 clk = ~clk;

   masked_streaming_histogram u_dut (
      .clk(clk), .rst(rst), .clear(clear), .busy(busy),
      .stream_valid(stream_valid), .stream_keep(stream_keep), .stream_data(stream_data),
      .query_valid(query_valid), .query_word(query_word),
      .query_count_valid(query_count_valid), .query_count(query_count),
      .drop_count(drop_count)
   );

   masked_streaming_histogram #(.count_width(4), .drop_width(4)) u_dut4 (
      .clk(clk), .rst(rst), .clear(clear4), .busy(busy4),
      .stream_valid(sv4), .stream_keep(keep4), .stream_data(data4),
      .query_valid(qv4), .query_word(qw4),
      .query_count_valid(qcv4), .query_count(qc4),
      .drop_count(drop4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic queryCheck(input string name, input logic [WW-1:0] word, input logic [CW-1:0] expCount);
      query_word  = word;
      query_valid = 1'b1;
      tick();
      query_valid = 1'b0;
      tick();
      checkOutput({name, ".early"}, 64'(query_count_valid), 64'd0);
      tick();
      checkOutput({name, ".valid"}, 64'(query_count_valid), 64'd1);
      checkOutput({name, ".count"}, 64'(query_count), 64'(expCount));
   endtask

   task automatic applyStimulus(input qvec_t tbl[$], input string tag);
      for (int i = 0; i < tbl.size(); i++) begin
         queryCheck($sformatf("%s[%0d]", tag, i), tbl[i].word, tbl[i].expCount);
      end
   endtask

   function automatic int laneHits(input logic [DW-1:0] d, input logic [L-1:0] k, input logic [WW-1:0] w);
      int n = 0;
      for (int i = 0; i < L; i++) begin
         if (k[i] && (d[i*WW +: WW] == w)) n++;
      end
      return n;
   endfunction

   task automatic verifyQuery(input qrec_t rec);
      logic [CW-1:0] c0, c1, c2, c3, c4;
      if (!rec.valid) begin
         checkOutput("rndQValid", 64'(query_count_valid), 64'd0);
      end else begin
         checkOutput("rndQValid", 64'(query_count_valid), 64'd1);
         if (rec.busy) begin
            checkOutput("rndQBusy", 64'(query_count), 64'd0);
         end else begin
            c0 = rec.base;
            c1 = c0 + rec.inc3;
            c2 = c1 + rec.inc2;
            c3 = c2 + rec.inc1;
            c4 = c3 + rec.inc0;
            checks++;
            if (!(query_count === c0 || query_count === c1 || query_count === c2 ||
                  query_count === c3 || query_count === c4)) begin
               errors++;
               $display("[TB] FAIL rndQCount word=%h: got %0d expected one of %0d %0d %0d %0d %0d",
                        rec.word, query_count, c0, c1, c2, c3, c4);
            end
         end
      end
   endtask

   task automatic randomCycle(input bit doRst, input bit allowQuery);
      logic [DW-1:0] d;
      logic [L-1:0]  k;
      logic [WW-1:0] qw;
      bit            sv, qv, busyBefore, acc;
      qrec_t         rec;
      for (int i = 0; i < L; i++) d[i*WW +: WW] = WW'($urandom_range(0, 15));
      k  = L'($urandom);
      sv = ($urandom_range(0, 3) != 0);
      qv = allowQuery && ($urandom_range(0, 1) == 1);
      qw = ($urandom_range(0, 7) == 0) ? WW'($urandom) : WW'($urandom_range(0, 15));
      rst = doRst; clear = 1'b0;
      stream_valid = sv; stream_keep = k; stream_data = d;
      query_valid = qv; query_word = qw;
      busyBefore = (modelRem > 0);
      tick();
      if (doRst) begin
         modelRem  = N;
         modelDrop = 0;
         for (int b = 0; b < N; b++) modelBins[b] = '0;
         for (int r = 0; r < 4; r++) begin
            ringAcc[r] = 1'b0; ringData[r] = '0; ringKeep[r] = '0;
         end
      end else begin
         acc = sv && !busyBefore;
         if (sv && busyBefore && modelDrop < 65535) modelDrop++;
         if (modelRem > 0) modelRem--;
         for (int r = 3; r > 0; r--) begin
            ringAcc[r] = ringAcc[r-1]; ringData[r] = ringData[r-1]; ringKeep[r] = ringKeep[r-1];
         end
         ringAcc[0] = acc; ringData[0] = d; ringKeep[0] = k;
         if (acc) begin
            for (int i = 0; i < L; i++) begin
               if (k[i]) modelBins[d[i*WW +: WW]] = modelBins[d[i*WW +: WW]] + 48'd1;
            end
         end
      end
      rec.valid = qv && !doRst;
      rec.busy  = busyBefore;
      rec.word  = qw;
      rec.inc0  = ringAcc[0] ? CW'(laneHits(ringData[0], ringKeep[0], qw)) : '0;
      rec.inc1  = ringAcc[1] ? CW'(laneHits(ringData[1], ringKeep[1], qw)) : '0;
      rec.inc2  = ringAcc[2] ? CW'(laneHits(ringData[2], ringKeep[2], qw)) : '0;
      rec.inc3  = ringAcc[3] ? CW'(laneHits(ringData[3], ringKeep[3], qw)) : '0;
      rec.base  = modelBins[qw] - rec.inc0 - rec.inc1 - rec.inc2 - rec.inc3;
      recQ.push_back(rec);
      if (recQ.size() == 3) verifyQuery(recQ.pop_front());
      checkOutput("rndBusy", 64'(busy), 64'(modelRem > 0));
      checkOutput("rndDrop", 64'(drop_count), 64'(modelDrop));
   endtask

   // Hard time limit so the run always ends even if the design stalls.
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   // Main test sequence.
   initial begin
      int cnt;
      runTable.push_back('{word: 12'h0AB, expCount: 48'd84});
      runTable.push_back('{word: 12'h0AC, expCount: 48'd0});
      runTable.push_back('{word: 12'h001, expCount: 48'd1});
      runTable.push_back('{word: 12'h002, expCount: 48'd0});
      runTable.push_back('{word: 12'h003, expCount: 48'd1});
      runTable.push_back('{word: 12'h004, expCount: 48'd0});
      runTable.push_back('{word: 12'h005, expCount: 48'd1});
      runTable.push_back('{word: 12'h006, expCount: 48'd0});
      runTable.push_back('{word: 12'h007, expCount: 48'd1});
      runTable.push_back('{word: 12'h008, expCount: 48'd0});
      runTable.push_back('{word: 12'h0AA, expCount: 48'd0});
      zeroTable.push_back('{word: 12'h0AB, expCount: 48'd0});
      zeroTable.push_back('{word: 12'h001, expCount: 48'd0});
      zeroTable.push_back('{word: 12'h003, expCount: 48'd0});
      zeroTable.push_back('{word: 12'h007, expCount: 48'd0});

      rst = 1'b1; clear = 1'b0; stream_valid = 1'b0; stream_keep = '0; stream_data = '0;
      query_valid = 1'b0; query_word = '0;
      clear4 = 1'b0; sv4 = 1'b0; keep4 = '0; data4 = '0; qv4 = 1'b0; qw4 = '0;
      tick();
      tick();
      checkOutput("rstBusy", 64'(busy), 64'd1);
      checkOutput("rstQValid", 64'(query_count_valid), 64'd0);
      checkOutput("rstQCount", 64'(query_count), 64'd0);
      checkOutput("rstDrop", 64'(drop_count), 64'd0);

      // Initial sweep length, a query while busy, and small-counter drop saturation.
      rst = 1'b0;
      sv4 = 1'b1;
      cnt = 0;
      while (busy === 1'b1 && cnt < 5000) begin
         if (cnt == 20) sv4 = 1'b0;
         if (cnt == 50) begin query_word = 12'h123; query_valid = 1'b1; end
         if (cnt == 51) query_valid = 1'b0;
         if (cnt == 52) checkOutput("busyQ.early", 64'(query_count_valid), 64'd0);
         if (cnt == 53) begin
            checkOutput("busyQ.valid", 64'(query_count_valid), 64'd1);
            checkOutput("busyQ.count", 64'(query_count), 64'd0);
         end
         tick();
         cnt++;
      end
      checkOutput("sweepLen", 64'(cnt), 64'd4096);
      checkOutput("dropSat4", 64'(drop4), 64'd15);
      checkOutput("dropIdle", 64'(drop_count), 64'd0);
      queryCheck("idleQ123", 12'h123, 48'd0);

      // Back-to-back identical beats, a masked beat, a partial-keep beat and a no-op beat.
      stream_valid = 1'b1; stream_keep = 8'hFF; stream_data = {L{12'h0AB}};
      for (int i = 0; i < 10; i++) tick();
      stream_keep = 8'h55;
      for (int i = 0; i < L; i++) stream_data[i*WW +: WW] = WW'(i + 1);
      tick();
      stream_keep = 8'h0F; stream_data = {L{12'h0AB}};
      tick();
      stream_keep = 8'h00;
      tick();
      stream_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      applyStimulus(runTable, "run");
      checkOutput("noopDrop", 64'(drop_count), 64'd0);
      checkOutput("runBusy", 64'(busy), 64'd0);

      // Counter overflow on the 4-bit instance: 24 increments in three beats.
      sv4 = 1'b1; keep4 = 8'hFF; data4 = {L{12'h010}};
      for (int i = 0; i < 3; i++) tick();
      sv4 = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      qw4 = 12'h010; qv4 = 1'b1;
      tick();
      qv4 = 1'b0;
      tick();
      tick();
      checkOutput("sat4.valid", 64'(qcv4), 64'd1);
`ifdef HIST_SATURATE_EN
      checkOutput("sat4.count", 64'(qc4), 64'd15);
`else
      checkOutput("sat4.count", 64'(qc4), 64'd8);
`endif

      // Clear during streaming, drops while sweeping, then a restart mid-sweep.
      stream_valid = 1'b1; stream_keep = 8'hFF; stream_data = {L{12'h0AB}};
      for (int i = 0; i < 3; i++) tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      stream_valid = 1'b0;
      checkOutput("clrDrop", 64'(drop_count), 64'd5);
      checkOutput("clrBusy", 64'(busy), 64'd1);
      queryCheck("clrBusyQ", 12'h0AB, 48'd0);
      for (int i = 0; i < 50; i++) tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checkOutput("restartDrop", 64'(drop_count), 64'd5);
      cnt = 0;
      while (busy === 1'b1 && cnt < 5000) begin
         tick();
         cnt++;
      end
      checkOutput("restartLen", 64'(cnt), 64'd4096);
      applyStimulus(zeroTable, "zero");

      // Randomised stream with interleaved queries and a reset in the middle.
      randomCycle(1'b1, 1'b0);
      while (modelRem > 0) randomCycle(1'b0, 1'b1);
      for (int i = 0; i < 650; i++) randomCycle(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) randomCycle(1'b0, 1'b0);
      randomCycle(1'b1, 1'b0);
      while (modelRem > 0) randomCycle(1'b0, 1'b1);
      for (int i = 0; i < 650; i++) randomCycle(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) randomCycle(1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
